// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the pipeline forwarding/hazard logic.
// Build option: define FWD_LOAD_STALL_EN to enable load-use stall detection.
package riscv_hazard_pkg;

  localparam int REG_AW = 5;

  // One-hot operand source encodings, ordered {G1, G2, regfile}
  localparam logic [2:0] FWD_G1 = 3'b100;
  localparam logic [2:0] FWD_G2 = 3'b010;
  localparam logic [2:0] FWD_RF = 3'b001;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } slot_t;

endpackage

// File: rtl/fwd_sel_enc.sv
// Compares one source register against the EX and MEM tracking slots and
// produces the one-hot operand-source select for it.
module fwd_sel_enc
  import riscv_hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  slot_t             ex_slot,
  input  slot_t             mem_slot,
  output logic [2:0]        sel
);

  // The load flag only matters to hazard detection, not to source selection
  logic unused_load;
  assign unused_load = ex_slot.load ^ mem_slot.load;

  // x0 is hard-wired zero; the younger producer (EX) shadows the older (MEM)
  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (ex_slot.we && (ex_slot.rd == rs)) begin
        sel = FWD_G1;
      end else if (mem_slot.we && (mem_slot.rd == rs)) begin
        sel = FWD_G2;
      end
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller sitting between ID and EX.
// Build option: FWD_LOAD_STALL_EN enables load-use stall and stall counting.
module fwd_ctrl #(
  parameter int REG_AW = 5,  // must match riscv_hazard_pkg::REG_AW
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              ex_flush_i,
  output logic              stall_o,
  output logic              FW00,
  output logic              FW01,
  output logic              FW02,
  output logic              FW10,
  output logic              FW11,
  output logic              FW12,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  import riscv_hazard_pkg::*;

  slot_t      ex_slot;
  slot_t      mem_slot;
  logic [2:0] sel1;
  logic [2:0] sel2;
  logic [2:0] fw1_q;
  logic [2:0] fw2_q;
  logic       id_load;
  logic       bubble;

`ifdef FWD_LOAD_STALL_EN
  logic             hazard;
  logic [CNT_W-1:0] stall_cnt_q;

  assign id_load = id_mem_read_i;
  assign hazard  = id_valid_i && ex_slot.load && (ex_slot.rd != '0) &&
                   ((ex_slot.rd == id_rs1_i) || (ex_slot.rd == id_rs2_i));
  // A taken branch kills the consumer, so there is nothing to stall for
  assign stall_o = hazard & ~ex_flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_o) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_mem_read;

  assign unused_mem_read = id_mem_read_i;
  assign id_load         = 1'b0;
  assign stall_o         = 1'b0;
  assign stall_cnt_o     = '0;
`endif

  assign bubble = ~id_valid_i | stall_o | ex_flush_i;

  fwd_sel_enc u_enc_rs1 (
    .rs       (id_rs1_i),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (sel1)
  );

  fwd_sel_enc u_enc_rs2 (
    .rs       (id_rs2_i),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (sel2)
  );

  // Selects are registered so they line up with the instruction's EX cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      fw1_q    <= FWD_RF;
      fw2_q    <= FWD_RF;
    end else begin
      mem_slot.rd   <= ex_slot.rd;
      mem_slot.we   <= ex_slot.we;
      mem_slot.load <= 1'b0;
      if (bubble) begin
        ex_slot <= '0;
        fw1_q   <= FWD_RF;
        fw2_q   <= FWD_RF;
      end else begin
        ex_slot.rd   <= id_rd_i;
        ex_slot.we   <= id_reg_write_i;
        ex_slot.load <= id_load;
        fw1_q        <= sel1;
        fw2_q        <= sel2;
      end
    end
  end

  assign {FW00, FW01, FW02} = fw1_q;
  assign {FW10, FW11, FW12} = fw2_q;

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and hazard controller for the 5-stage RISC-V pipeline. It tracks the destination register of every instruction in flight past decode and issues registered one-hot operand-source selects (FW00/FW01/FW02 for rs1, FW10/FW11/FW12 for rs2) to the EX-stage forwarding mux. It also detects load-use hazards, raises a decode stall and counts stall cycles. It sits between ID and EX, upstream of the operand mux that picks between G1 (EX/MEM result), G2 (MEM/WB result) and the register-file values A/B.

## Interface
Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i  in  REG_AW  ID source register 1.
- id_rs2_i  in  REG_AW  ID source register 2.
- id_rd_i  in  REG_AW  ID destination register.
- id_reg_write_i  in  1  ID instruction writes rd.
- id_mem_read_i  in  1  ID instruction is a load.
- ex_flush_i  in  1  branch/jump taken in EX; kills the ID instruction.
- stall_o  out  1  hold PC and IF/ID; insert a bubble into EX (combinational).
- FW00, FW01, FW02  out  1 each  rs1 source: G1 / G2 / A (one-hot).
- FW10, FW11, FW12  out  1 each  rs2 source: G1 / G2 / B (one-hot).
- stall_cnt_o  out  CNT_W  cycles with stall_o asserted, wrapping.

## Operation
- Tracking slots: EX slot {rd, we, load} and MEM slot {rd, we}. Each clock, EX shifts into MEM and the ID instruction is captured into EX.
- EX capture is a bubble (we=0, load=0) when any of these hold: id_valid_i=0, stall_o=1, or ex_flush_i=1.
- Select computation, done at ID for the instruction entering EX next cycle, per source rs:
  - rs==0: select the regfile (FW02 / FW12). x0 is never forwarded.
  - Else if EX slot we and EX.rd==rs: select G1. At consume time that producer is in EX/MEM.
  - Else if MEM slot we and MEM.rd==rs: select G2.
  - Else: select the regfile.
  - EX-slot match has priority over MEM-slot match.
- Registered selects load the computed triple on every clock. When the EX capture is a bubble, they load the regfile select (001) instead.
- Each triple is exactly one-hot at all times.
- Load-use hazard: EX slot load=1, EX.rd!=0, and EX.rd equals id_rs1_i or id_rs2_i, with id_valid_i=1.
  - stall_o = hazard & ~ex_flush_i.
  - After the one-cycle stall, the producer sits in the MEM slot, so the retried consumer gets G2.
- Write-back to the register file is write-first in the same cycle. No third forwarding source is needed.
- stall_cnt_o increments on each cycle with stall_o=1 and wraps from all-ones to 0.

## Timing
- Reset values (asynchronous, active-low):
  - slots cleared (we=0, load=0, rd=0).
  - FW02=FW12=1, all other FW outputs 0.
  - stall_cnt_o=0.
  - stall_o=0, since the slots are empty.
- Select latency: computed in the ID cycle, valid in the same cycle the instruction is in EX. The registered outputs are aligned with G1/G2/A/B.
- stall_o is combinational from the ID inputs and the EX slot, valid in the same cycle.
- Simultaneous flush and hazard: flush wins, stall_o=0, and a bubble enters EX.
- Back-to-back loads feeding each other: one stall per dependent pair, never two.
- Reset asserted mid-operation: all slots and outputs return to reset values immediately. Any in-flight forwarding state is discarded.

## Configuration
- Macro: FWD_LOAD_STALL_EN.
- Defined: load-use detection, stall_o and stall_cnt_o behave as described above.
- Undefined:
  - stall_o is tied to 0 and stall_cnt_o is tied to 0.
  - The load flag is not tracked.
  - A load-use pair selects G1 (the address, not the data). Software must schedule around it.

## Structure
- Shared package riscv_hazard_pkg holds:
  - REG_AW.
  - One-hot source constants FWD_G1=3'b100, FWD_G2=3'b010, FWD_RF=3'b001.
  - The slot struct typedef {rd, we, load}.
- One sub-module, fwd_sel_enc: combinational compare of rs against both slots, producing the one-hot triple. It is instantiated twice (rs1, rs2).

## Test plan
- Reset release, no instructions → FW02=FW12=1, stall_o=0, stall_cnt_o=0.
- add x5 then add x6,x5,x5 back-to-back → FW00=FW10=1 in the consumer's EX cycle.
- add x5, nop, sub x7,x5,x2 → FW01=1 (rs1), FW12=1 (rs2). With x5 written by both of two consecutive producers, the second producer wins (G1).
- lw x8 then add x9,x8,x1 → stall_o=1 for exactly one cycle, then FW01=1, stall_cnt_o=1. With FWD_LOAD_STALL_EN undefined: no stall, FW00=1.
- Load-use hazard with ex_flush_i=1 in the same cycle → stall_o=0, next-cycle selects 001/001.
- Producer with rd=x0 followed by a consumer of x0 → FW02=1, no stall. Assert rst_n=0 mid-sequence → outputs return to reset values asynchronously.
